// File: rtl/video_pattern_gen.sv
// Synthetic camera source: raster timing generator with selectable 8-bit test patterns.
module video_pattern_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_BLANK    = 160,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_BLANK    = 45,
   parameter int unsigned CHECK_SIZE = 32
) (
   input  logic       p_clk,
   input  logic       p_resetn,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       frame_valid,
   output logic       line_valid,
   output logic [7:0] pixel_out,
   output logic       frame_start,
   output logic [7:0] frame_cnt,
   output logic       busy
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned CW      = $clog2(CHECK_SIZE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [HW-1:0]   h_cnt, h_nx;
   logic [VW-1:0]   v_cnt, v_nx;
   logic [1:0]      pat_q, pat_nx;
   logic [7:0]      fc_nx;
   logic            last_pix;
   logic            act_nx, fv_nx, lv_nx, fs_nx;
   logic [7:0]      pat_pix, pix_nx;

   // State, raster position and latched pattern registers.
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
         pat_q <= '0;
      end else begin
         state <= state_nx;
         h_cnt <= h_nx;
         v_cnt <= v_nx;
         pat_q <= pat_nx;
      end
   end

   // Next-state, counter advance and frame-boundary decisions; frames always run to completion.
   always_comb begin
      state_nx = state;
      h_nx     = h_cnt;
      v_nx     = v_cnt;
      pat_nx   = pat_q;
      fc_nx    = frame_cnt;
      last_pix = (h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1));
      case (state)
         IDLE: begin
            h_nx = '0;
            v_nx = '0;
            if (enable) begin
               state_nx = RUN;
               pat_nx   = pattern_sel;
            end
         end
         RUN, DRAIN: begin
            if (last_pix) begin
               fc_nx = frame_cnt + 8'd1;
               h_nx  = '0;
               v_nx  = '0;
               if (enable) begin
                  state_nx = RUN;
                  pat_nx   = pattern_sel;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               state_nx = enable ? RUN : DRAIN;
               if (h_cnt == HW'(H_TOTAL - 1)) begin
                  h_nx = '0;
                  v_nx = v_cnt + VW'(1);
               end else begin
                  h_nx = h_cnt + HW'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            h_nx     = '0;
            v_nx     = '0;
         end
      endcase
   end

   // Output values for the pixel that will be presented after the next edge.
   always_comb begin
      act_nx = (state_nx != IDLE);
      fv_nx  = act_nx && (v_nx < VW'(V_ACTIVE));
      lv_nx  = fv_nx && (h_nx < HW'(H_ACTIVE));
      fs_nx  = act_nx && (h_nx == '0) && (v_nx == '0);
      case (pat_nx)
         2'd0:    pat_pix = 8'(h_nx);
         2'd1:    pat_pix = 8'(v_nx);
         2'd2:    pat_pix = (h_nx[CW] ^ v_nx[CW]) ? 8'h00 : 8'hFF;
         default: pat_pix = 8'(h_nx) + 8'(v_nx) + fc_nx;
      endcase
      pix_nx = lv_nx ? pat_pix : 8'h00;
   end

   // Registered video outputs and status.
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         frame_valid <= 1'b0;
         line_valid  <= 1'b0;
         pixel_out   <= 8'h00;
         frame_start <= 1'b0;
         frame_cnt   <= 8'h00;
         busy        <= 1'b0;
      end else begin
         frame_valid <= fv_nx;
         line_valid  <= lv_nx;
         pixel_out   <= pix_nx;
         frame_start <= fs_nx;
         frame_cnt   <= fc_nx;
         busy        <= act_nx;
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a reduced raster so full-frame and frame-count-wrap runs stay short.
module tb_video_pattern_gen;

   localparam int HA = 12;
   localparam int HB = 4;
   localparam int VA = 10;
   localparam int VB = 2;
   localparam int CS = 4;
   localparam int L  = HA + HB;        // 16 clocks per line
   localparam int F  = L * (VA + VB);  // 192 clocks per frame

   logic       p_clk = 1'b0;
   logic       p_resetn = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] pattern_sel = 2'd0;
   logic       frame_valid, line_valid, frame_start, busy;
   logic [7:0] pixel_out, frame_cnt;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int off = 0;

   video_pattern_gen #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CHECK_SIZE(CS)
   ) dut (
      .p_clk(p_clk), .p_resetn(p_resetn), .enable(enable), .pattern_sel(pattern_sel),
      .frame_valid(frame_valid), .line_valid(line_valid), .pixel_out(pixel_out),
      .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
   );

   always #20 p_clk = ~p_clk;

   // Reference: running flag, linear pixel index within the frame, frame count, latched pattern.
   bit m_act = 1'b0;
   int m_p   = 0;
   int m_fc  = 0;
   int m_pat = 0;

   always @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         m_act = 1'b0; m_p = 0; m_fc = 0; m_pat = 0;
      end else if (!m_act) begin
         if (enable) begin
            m_act = 1'b1; m_p = 0; m_pat = int'(pattern_sel);
         end
      end else if (m_p == F - 1) begin
         m_fc = (m_fc + 1) % 256;
         m_p  = 0;
         if (enable) m_pat = int'(pattern_sel);
         else        m_act = 1'b0;
      end else begin
         m_p = m_p + 1;
      end
   end

   function automatic int exp_pix(int pat, int x, int y, int fc);
      case (pat)
         0:       return x % 256;
         1:       return y % 256;
         2:       return ((((x / CS) ^ (y / CS)) & 1) != 0) ? 0 : 255;
         default: return (x + y + fc) % 256;
      endcase
   endfunction

   // Per-cycle comparison of every output against the reference, away from the active edge.
   always @(negedge p_clk) begin
      int x, y, e_fv, e_lv, e_pix, e_fs, e_busy;
      logic [19:0] act_v, exp_v;
      cyc++;
      x = m_p % L;
      y = m_p / L;
      e_busy = m_act ? 1 : 0;
      e_fv   = (m_act && y < VA) ? 1 : 0;
      e_lv   = (e_fv == 1 && x < HA) ? 1 : 0;
      e_pix  = (e_lv == 1) ? exp_pix(m_pat, x, y, m_fc) : 0;
      e_fs   = (m_act && m_p == 0) ? 1 : 0;
      act_v  = {frame_valid, line_valid, pixel_out, frame_start, frame_cnt, busy};
      exp_v  = {1'(e_fv), 1'(e_lv), 8'(e_pix), 1'(e_fs), 8'(m_fc), 1'(e_busy)};
      vectors++;
      if (act_v !== exp_v) begin
         miscompares++;
         $display("FAIL cycle %0d model: got fv=%b lv=%b pix=%h fs=%b fc=%0d busy=%b, expected fv=%0d lv=%0d pix=%h fs=%0d fc=%0d busy=%0d",
                  cyc, frame_valid, line_valid, pixel_out, frame_start, frame_cnt, busy,
                  e_fv, e_lv, 8'(e_pix), e_fs, m_fc, e_busy);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge p_clk);
      #1;
   endtask

   task automatic to_off(input int target);
      while (off < target) begin
         tick;
         off++;
      end
   endtask

   task automatic next_frame(output int n);
      n = 0;
      do begin
         tick;
         n++;
      end while (!frame_start && n < 2 * F + 2);
      if (!frame_start) check("frame_start timeout", 0, 1);
      off = 0;
   endtask

   initial begin
      int n, lvc, fvc, fsc;

      // Reset held: everything low.
      #1 p_resetn = 1'b0;
      repeat (3) tick;
      check("reset busy", int'(busy), 0);
      check("reset frame_valid", int'(frame_valid), 0);
      check("reset pixel", int'(pixel_out), 0);
      check("reset frame_cnt", int'(frame_cnt), 0);
      p_resetn = 1'b1;
      repeat (5) tick;
      check("idle busy", int'(busy), 0);
      check("idle frame_start", int'(frame_start), 0);

      // Frame 0, h-ramp: first pixel one cycle after enable, then measure raster timing.
      pattern_sel = 2'd0;
      enable = 1'b1;
      tick;
      off = 0;
      check("first frame_start", int'(frame_start), 1);
      check("first line_valid", int'(line_valid), 1);
      check("first pixel", int'(pixel_out), 0);
      n = 0; lvc = 0; fvc = 0;
      do begin
         lvc += int'(line_valid);
         fvc += int'(frame_valid);
         if (n == 3 * L + 7) check("p0 pixel(7,3)", int'(pixel_out), 7);
         if (n == 2 * L + HA) check("hblank lv", int'(line_valid), 0);
         if (n == 2 * L + HA) check("hblank fv", int'(frame_valid), 1);
         tick;
         n++;
      end while (!frame_start && n < 4 * F);
      off = 0;
      check("frame period", n, 192);
      check("line_valid per frame", lvc, 120);
      check("frame_valid per frame", fvc, 160);
      check("frame_cnt after frame0", int'(frame_cnt), 1);

      // Frame 1: switch to checkerboard mid-frame, ramp continues.
      to_off(5 * L);
      pattern_sel = 2'd2;
      to_off(6 * L + 4);
      check("sel change ramp pixel(4,6)", int'(pixel_out), 4);
      next_frame(n);

      // Frame 2: checkerboard.
      check("chk pixel(0,0)", int'(pixel_out), 255);
      to_off(4);
      check("chk pixel(4,0)", int'(pixel_out), 0);
      to_off(4 * L + 4);
      check("chk pixel(4,4)", int'(pixel_out), 255);
      pattern_sel = 2'd3;
      next_frame(n);

      // Frame 3: moving diagonal, 1+1+3.
      check("frame_cnt frame3", int'(frame_cnt), 3);
      to_off(L + 1);
      check("diag pixel(1,1)", int'(pixel_out), 5);
      pattern_sel = 2'd1;
      next_frame(n);

      // Frame 4: v-ramp, then drop enable on line 7 and let it drain.
      to_off(6 * L + 10);
      check("vramp pixel(10,6)", int'(pixel_out), 6);
      to_off(7 * L);
      enable = 1'b0;
      lvc = 0; fsc = 0;
      while (busy && off < 2 * F) begin
         lvc += int'(line_valid);
         tick;
         off++;
         fsc += int'(frame_start);
      end
      check("drain ends at frame end", off, F);
      check("drain remaining lv", lvc, 36);
      check("drain no new frame", fsc, 0);
      check("drain frame_cnt", int'(frame_cnt), 5);
      check("drain idle fv", int'(frame_valid), 0);
      repeat (4) tick;
      check("post-drain busy", int'(busy), 0);

      // Restart, drop enable, re-assert during drain: next frame follows back-to-back.
      enable = 1'b1;
      tick;
      off = 0;
      check("restart frame_start", int'(frame_start), 1);
      to_off(2 * L);
      enable = 1'b0;
      to_off(7 * L);
      enable = 1'b1;
      next_frame(n);
      check("reenable gap", n, F - 7 * L);
      check("reenable frame_cnt", int'(frame_cnt), 6);

      // Asynchronous reset mid-line.
      to_off(3 * L + 5);
      #3 p_resetn = 1'b0;
      #1;
      check("async rst lv", int'(line_valid), 0);
      check("async rst fv", int'(frame_valid), 0);
      check("async rst pixel", int'(pixel_out), 0);
      check("async rst frame_cnt", int'(frame_cnt), 0);
      check("async rst busy", int'(busy), 0);
      @(posedge p_clk);
      #1 p_resetn = 1'b1;

      // 256 frames of moving diagonal: frame_cnt wraps to 0.
      pattern_sel = 2'd3;
      enable = 1'b1;
      tick;
      off = 0;
      check("post-reset frame_start", int'(frame_start), 1);
      for (int i = 1; i < 256; i++) next_frame(n);
      check("frame_cnt 255", int'(frame_cnt), 255);
      next_frame(n);
      check("frame_cnt wrap", int'(frame_cnt), 0);
      enable = 1'b0;
      n = 0;
      while (busy && n < 2 * F) begin
         tick;
         n++;
      end
      check("final idle", int'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
